// File: rtl/mix_columns_seq.sv
// mix_columns_seq: column-serial MixColumns/InvMixColumns sequencer sharing PAR
// combinational column units across the four columns of an AES state.
module mix_columns_mix (
    input  logic [31:0] col_i,
    input  logic        inv_en_i,
    output logic [31:0] col_o
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
    logic [7:0] a0, a1, a2, a3, u, v, t;
    // InvMixColumns = MixColumns applied after a cheap {4,0,4,0}-style pre-mix
    always_comb begin
        u  = inv_en_i ? xt(xt(col_i[31:24] ^ col_i[15:8])) : 8'h00;
        v  = inv_en_i ? xt(xt(col_i[23:16] ^ col_i[7:0])) : 8'h00;
        a0 = col_i[31:24] ^ u;
        a1 = col_i[23:16] ^ v;
        a2 = col_i[15:8] ^ u;
        a3 = col_i[7:0] ^ v;
        t  = a0 ^ a1 ^ a2 ^ a3;
    end
    assign col_o = {a0 ^ t ^ xt(a0 ^ a1), a1 ^ t ^ xt(a1 ^ a2),
                    a2 ^ t ^ xt(a2 ^ a3), a3 ^ t ^ xt(a3 ^ a0)};
endmodule

module mix_columns_seq #(
    parameter int PAR = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    localparam int NCYC = 4 / PAR;
    localparam int CW = (NCYC > 1) ? $clog2(NCYC) : 1;

    if (PAR != 1 && PAR != 2 && PAR != 4) begin : g_bad_par
        $error("mix_columns_seq: PAR must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [31:0]   src_q [4];
    logic [31:0]   res_q [4];
    logic          inv_q;
    logic          accept, last;
    logic [1:0]    idx [PAR];
    logic [31:0]   mix_in [PAR];
    logic [31:0]   mix_out [PAR];

    genvar p;
    for (p = 0; p < PAR; p++) begin : g_unit
        assign idx[p]    = 2'(int'(col_q) * PAR + p);
        assign mix_in[p] = src_q[idx[p]];
        mix_columns_mix u_mix (.col_i(mix_in[p]), .inv_en_i(inv_q), .col_o(mix_out[p]));
    end

    assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign last      = col_q == CW'(NCYC - 1);
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign out_state = {res_q[0], res_q[1], res_q[2], res_q[3]};

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        case (state_q)
            IDLE: begin
                state_d = accept ? RUN : IDLE;
                col_d   = '0;
            end
            RUN: begin
                state_d = last ? DONE : RUN;
                col_d   = last ? '0 : col_q + CW'(1);
            end
            DONE: begin
                state_d = out_ready ? (in_valid ? RUN : IDLE) : DONE;
                col_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            inv_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                src_q[i] <= '0;
                res_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            if (accept) begin
                inv_q <= in_inv;
                for (int i = 0; i < 4; i++) src_q[i] <= in_state[127-32*i -: 32];
            end
            if (state_q == RUN)
                for (int j = 0; j < PAR; j++) res_q[idx[j]] <= mix_out[j];
        end
    end
endmodule

// File: tb/tb_mix_columns_seq.sv
// tb_mix_columns_seq: PAR=1/2/4 instances checked against a GF(2^8) matrix model.
module tb_mix_columns_seq;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] in_state = '0;
    logic         in_inv = 1'b0;
    logic         iv [3];
    logic         ordy [3];
    logic         ir [3];
    logic         ov [3];
    logic         bz [3];
    logic [127:0] os [3];
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    mix_columns_seq #(.PAR(1)) u_p1 (.clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_state(in_state), .in_inv(in_inv), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_state(os[0]), .busy(bz[0]));
    mix_columns_seq #(.PAR(2)) u_p2 (.clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_state(in_state), .in_inv(in_inv), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_state(os[1]), .busy(bz[1]));
    mix_columns_seq #(.PAR(4)) u_p4 (.clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_state(in_state), .in_inv(in_inv), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out_state(os[2]), .busy(bz[2]));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
        logic [7:0]   cf [4];
        logic [7:0]   acc;
        logic [127:0] r;
        if (inv) cf = '{8'd14, 8'd11, 8'd13, 8'd9};
        else     cf = '{8'd2, 8'd3, 8'd1, 8'd1};
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc ^= gmul(cf[(k - row + 4) % 4], s[127-32*c-8*k -: 8]);
                r[127-32*c-8*row -: 8] = acc;
            end
        return r;
    endfunction

    task automatic run_vec(input int k, input logic [127:0] s, input logic inv,
                           input logic [127:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        in_state = s;
        in_inv   = inv;
        iv[k]    = 1'b1;
        ordy[k]  = 1'b1;
        check("in_ready_idle", 128'(ir[k]), 128'd1);
        @(posedge clk);
        #1;
        iv[k]    = 1'b0;
        in_state = {$urandom, $urandom, $urandom, $urandom};
        in_inv   = ~inv;
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!ov[k] && lat < 20);
        check("latency", 128'(lat), 128'(exp_lat));
        check("result", os[k], exp);
        @(posedge clk);
        #1;
        check("released", 128'(ov[k]), 128'd0);
        check("idle_busy", 128'(bz[k]), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] a, exp;
        int           lat, k;
        for (int i = 0; i < 3; i++) begin
            iv[i]   = 1'b0;
            ordy[i] = 1'b1;
        end
        #12;
        check("rst_out_state", os[0], '0);
        check("rst_out_valid", 128'(ov[0]), 128'd0);
        check("rst_busy", 128'(bz[0]), 128'd0);
        check("rst_in_ready", 128'(ir[0]), 128'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run_vec(0, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
                128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 4);
        run_vec(0, 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, 1'b1,
                128'hdb135345_f20a225c_d4d4d4d5_2d26314c, 4);
        run_vec(1, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
                128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 2);
        run_vec(2, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
                128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1);

        // Backpressure: output must hold and new inputs must be refused
        a = {$urandom, $urandom, $urandom, $urandom};
        exp = model(a, 1'b0);
        @(negedge clk);
        in_state = a;
        in_inv   = 1'b0;
        iv[0]    = 1'b1;
        ordy[0]  = 1'b0;
        @(posedge clk);
        #1 iv[0] = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!ov[0] && lat < 20);
        check("bp_latency", 128'(lat), 128'd4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            iv[0]    = 1'b1;
            in_state = ~a;
            in_inv   = 1'b1;
            @(posedge clk);
            #1;
            check("bp_valid", 128'(ov[0]), 128'd1);
            check("bp_hold", os[0], exp);
            check("bp_in_ready", 128'(ir[0]), 128'd0);
        end
        @(negedge clk);
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", 128'(ov[0]), 128'd0);
        check("bp_no_accept", 128'(bz[0]), 128'd0);
        repeat (3) begin
            @(posedge clk);
            #1 check("bp_once", 128'(ov[0]), 128'd0);
        end

        // Back-to-back: B (same state, inverse) accepted on A's consume edge
        a = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        in_state = a;
        in_inv   = 1'b0;
        iv[0]    = 1'b1;
        @(posedge clk);
        #1 in_inv = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!ov[0] && lat < 20);
        check("b2b_a_latency", 128'(lat), 128'd4);
        check("b2b_a_result", os[0], model(a, 1'b0));
        check("b2b_in_ready", 128'(ir[0]), 128'd1);
        @(posedge clk);
        #1 iv[0] = 1'b0;
        check("b2b_accept_busy", 128'(bz[0]), 128'd1);
        check("b2b_valid_drop", 128'(ov[0]), 128'd0);
        lat = 1;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!ov[0] && lat < 20);
        check("b2b_spacing", 128'(lat), 128'd5);
        check("b2b_b_result", os[0], model(a, 1'b1));
        @(posedge clk);
        #1 check("b2b_done", 128'(ov[0]), 128'd0);

        // Asynchronous reset with col_cnt == 2
        @(negedge clk);
        in_state = {$urandom | 32'h1, $urandom, $urandom, $urandom};
        in_inv   = 1'b0;
        iv[0]    = 1'b1;
        @(posedge clk);
        #1 iv[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_state", os[0], '0);
        check("arst_out_valid", 128'(ov[0]), 128'd0);
        check("arst_busy", 128'(bz[0]), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("arst_in_ready", 128'(ir[0]), 128'd1);
        repeat (6) begin
            @(posedge clk);
            #1 check("arst_no_stale", 128'(ov[0]), 128'd0);
        end

        for (int n = 0; n < 24; n++) begin
            k = int'($urandom_range(0, 2));
            a = {$urandom, $urandom, $urandom, $urandom};
            run_vec(k, a, n[0], model(a, n[0]), 4 >> k);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mix_columns_seq.md
Name:
mix_columns_seq

Overview:
- Column-serial sequencer for the MixColumns / InvMixColumns datapath.
- Accepts a full 128-bit AES state over a valid/ready handshake and processes it through PAR shared instances of the 32-bit mix_columns_mix column unit, PAR columns per cycle.
- Returns the transformed 128-bit state over a second valid/ready handshake.
- Sits between the round-state register and the AddRoundKey stage in the iterative encrypt/decrypt round.

Parameters:
- PAR, 1, columns processed per cycle. Legal values are 1, 2 and 4; any other value is a synthesis-time error.
- NCYC, 4/PAR, derived localparam: number of RUN cycles per state.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_state/in_inv valid
- in_ready  output  1  block can accept a state this cycle
- in_state  input  128  AES state; column c = bits [127-32c : 96-32c], byte 0 of column = MSB byte
- in_inv  input  1  0 = MixColumns, 1 = InvMixColumns
- out_valid  output  1  out_state valid
- out_ready  input  1  downstream accepts out_state
- out_state  output  128  transformed state, same column layout as in_state
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE and col_cnt to 0.
  - Internal src register, out_state, out_valid and busy are all 0.
  - in_ready is 1 in IDLE.
  - Reset asserted mid-operation aborts the state in flight, and no out_valid is produced for it.
- Input accept: in_valid && in_ready at a rising edge.
  - Latch in_state into src and in_inv into inv_q.
  - col_cnt goes to 0; FSM goes to RUN.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. Accept -> RUN.
  - RUN: in_ready=0.
    - Each cycle, columns col_cnt*PAR .. col_cnt*PAR+PAR-1 of src feed the PAR column units, with inv_en=inv_q.
    - Results are registered into the same column positions of out_state.
    - col_cnt increments. When col_cnt == NCYC-1, go to DONE and set out_valid=1 on that edge.
  - DONE: out_valid=1 and out_state is held stable until out_ready=1.
    - in_ready = out_ready, so a back-to-back handoff is possible.
    - out_ready && in_valid: the new state is accepted on the same edge, FSM goes to RUN, and out_valid drops to 0.
    - out_ready && !in_valid: FSM goes to IDLE and out_valid goes to 0.
    - !out_ready: stay in DONE. in_valid is ignored, because in_ready=0.
- Latency:
  - out_valid rises NCYC edges after the accept edge (4 for PAR=1, 1 for PAR=4).
  - Throughput is one state per NCYC+1 cycles with continuous out_ready, because the DONE cycle doubles as the next accept.
- inv_q is constant for a whole state. A change on in_inv outside an accept edge has no effect.
- Column units are pure combinational. A unit's result is written only in RUN, only into the columns indexed by the current col_cnt.
- Columns not yet written during RUN hold their previous contents. Downstream must sample only when out_valid=1.
- col_cnt is ceil(log2(NCYC)) bits, minimum 1 bit. With PAR=4 it stays 0 and RUN lasts exactly one cycle.
- in_state is not required to stay stable after the accept edge.
- busy = (FSM != IDLE).

Test Plan:
- Forward, PAR=1:
  - Stimulus: in_state = db135345_f20a225c_01010101_c6c6c6c6, in_inv=0, out_ready=1.
  - Required: out_state = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, with out_valid exactly 4 edges after accept.
- Inverse:
  - Stimulus: in_state = 8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, in_inv=1.
  - Required: out_state = db135345_f20a225c_d4d4d4d5_2d26314c.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid.
  - Required: out_state stable, in_ready=0, and a new in_valid is not accepted. Raising out_ready releases the output exactly once.
- Back-to-back:
  - Stimulus: in_valid continuously high, out_ready=1, states A then B, where B = A with in_inv=1.
  - Required: B is accepted on the same edge A is consumed, each result is correct, and the output spacing is 5 cycles.
- Reset mid-RUN:
  - Stimulus: assert rst_n=0 asynchronously with col_cnt=2.
  - Required: out_state=0, out_valid=0 and busy=0 immediately. After release, in_ready=1 and no stale output appears.
- PAR=4 and PAR=2 builds:
  - Stimulus: the forward vector.
  - Required: identical results, with out_valid 1 and 2 edges after accept respectively.
